// File: rtl/clk_div_prog_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_div_prog_if : control/status bundle for the programmable clock divider
// Revision 1.0
// ---------------------------------------------------------------------------
interface clk_div_prog_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             div_ack;
  logic             div_err;
  logic             clk_out;
  logic             tick;
  logic             busy;

  modport master (
    output en, div_val, div_load,
    input  div_ack, div_err, clk_out, tick, busy
  );

  modport slave (
    input  en, div_val, div_load,
    output div_ack, div_err, clk_out, tick, busy
  );
endinterface
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_div_prog : programmable divided clock + rising-edge tick, glitch-free reload
// Revision 1.0
// ---------------------------------------------------------------------------
module clk_div_prog #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  clk_div_prog_if.slave        bus
);

  localparam logic [1:0]       C_IDLE     = 2'd0;
  localparam logic [1:0]       C_RUN      = 2'd1;
  localparam logic [1:0]       C_STOPPING = 2'd2;
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] C_DEF_DIV  = CNT_W'(DEFAULT_DIV);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_cur;
  logic [CNT_W-1:0] r_pend_val;
  logic             r_pend;
  logic             r_clk_out;
  logic             r_tick;
  logic             r_ack;
  logic             r_err;

  logic             w_running;
  logic             w_boundary;
  logic             w_apply;
  logic             w_load_ok;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_hi;

  assign w_running  = (r_state != C_IDLE);
  assign w_boundary = w_running && (r_cnt == (r_div_cur - C_ONE));
  // A pending divisor only takes effect where a new period starts (or while idle).
  assign w_apply    = r_pend && (!w_running || w_boundary);
  assign w_load_ok  = bus.div_load && (bus.div_val >= C_TWO);
  assign w_cnt_inc  = r_cnt + C_ONE;
  assign w_hi       = r_div_cur - (r_div_cur >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= C_IDLE;
      r_cnt      <= '0;
      r_div_cur  <= C_DEF_DIV;
      r_pend_val <= '0;
      r_pend     <= 1'b0;
      r_clk_out  <= 1'b0;
      r_tick     <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_ack  <= w_apply;
      r_err  <= bus.div_load && !w_load_ok;

      if (w_apply) begin
        r_div_cur <= r_pend_val;
        r_pend    <= 1'b0;
      end
      // A load landing on the apply cycle re-arms pend for the following boundary.
      if (w_load_ok) begin
        r_pend     <= 1'b1;
        r_pend_val <= bus.div_val;
      end

      case (r_state)
        C_IDLE: begin
          r_cnt     <= '0;
          r_clk_out <= 1'b0;
          if (bus.en) begin
            r_state   <= C_RUN;
            r_clk_out <= 1'b1;
            r_tick    <= 1'b1;
          end
        end
        default: begin
          if (w_boundary) begin
            r_cnt <= '0;
            if (bus.en) begin
              r_state   <= C_RUN;
              r_clk_out <= 1'b1;
              r_tick    <= 1'b1;
            end else begin
              r_state   <= C_IDLE;
              r_clk_out <= 1'b0;
            end
          end else begin
            r_cnt     <= w_cnt_inc;
            r_clk_out <= (w_cnt_inc < w_hi);
            r_state   <= bus.en ? C_RUN : C_STOPPING;
          end
        end
      endcase
    end
  end

  assign bus.clk_out = r_clk_out;
  assign bus.tick    = r_tick;
  assign bus.div_ack = r_ack;
  assign bus.div_err = r_err;
  assign bus.busy    = w_running;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_clk_div_prog : directed + random checks of clk_div_prog against a period model
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clk_div_prog;

  localparam int CNT_W = 16;
  localparam int DEF   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  clk_div_prog_if #(.CNT_W(CNT_W)) bus ();

  clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: a running flag, position within the current period, period length, pending divisor.
  bit m_on;
  int m_pos;
  int m_n = DEF;
  bit m_pv;
  int m_pval;
  logic [4:0] exp_v = 5'b0;

  function automatic logic [4:0] outs();
    return {bus.clk_out, bus.tick, bus.div_ack, bus.div_err, bus.busy};
  endfunction

  task automatic model_step(bit r, bit e, bit ld, int v);
    bit ack = 0, err = 0, tk = 0, ck;
    if (r) begin
      m_on = 0; m_pos = 0; m_n = DEF; m_pv = 0;
      exp_v = 5'b0;
      return;
    end
    if (!m_on) begin
      if (m_pv) begin m_n = m_pval; m_pv = 0; ack = 1; end
      if (e) begin m_on = 1; m_pos = 0; tk = 1; end
    end else if (m_pos == m_n - 1) begin
      if (m_pv) begin m_n = m_pval; m_pv = 0; ack = 1; end
      m_pos = 0;
      if (e) tk = 1; else m_on = 0;
    end else begin
      m_pos++;
    end
    if (ld) begin
      if (v < 2) err = 1;
      else begin m_pv = 1; m_pval = v; end
    end
    ck = m_on && (m_pos < m_n - m_n / 2);
    exp_v = {ck, tk, ack, err, m_on};
  endtask

  task automatic cycle(bit r, bit e, bit ld, int v);
    rst          = r;
    bus.en       = e;
    bus.div_load = ld;
    bus.div_val  = CNT_W'(v);
    @(posedge clk);
    model_step(r, e, ld, v);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 0, 0);
      checks++;
      if (outs() !== 5'b0) begin
        failures++;
        $display("FAIL reset: got %b want %b", outs(), 5'b0);
      end
    end
  endtask

  task automatic test_default_div();
    int ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, 0, 0);
      ticks += int'(bus.tick);
      checks++;
      if (outs() !== exp_v) begin
        failures++;
        $display("FAIL default_div cyc%0d: got %b want %b", i, outs(), exp_v);
      end
    end
    checks++;
    if (ticks !== 3) begin
      failures++;
      $display("FAIL default_div_ticks: got %0d want 3", ticks);
    end
  endtask

  task automatic test_idle_load();
    int acks = 0;
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 5);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 0, 0);
      acks += int'(bus.div_ack);
      checks++;
      if (outs() !== exp_v) begin
        failures++;
        $display("FAIL idle_load cyc%0d: got %b want %b", i, outs(), exp_v);
      end
    end
    checks++;
    if (acks !== 1) begin
      failures++;
      $display("FAIL idle_load_acks: got %0d want 1", acks);
    end
  endtask

  task automatic test_running_load();
    int acks = 0;
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 22; i++) begin
      cycle(0, 1, i == 0, 6);
      acks += int'(bus.div_ack);
      checks++;
      if (outs() !== exp_v) begin
        failures++;
        $display("FAIL running_load cyc%0d: got %b want %b", i, outs(), exp_v);
      end
    end
    checks++;
    if (acks !== 1) begin
      failures++;
      $display("FAIL running_load_acks: got %0d want 1", acks);
    end
  endtask

  task automatic test_err();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      cycle(0, 1, (i == 3) || (i == 6), (i == 3) ? 1 : 0);
      checks++;
      if (outs() !== exp_v) begin
        failures++;
        $display("FAIL div_err cyc%0d: got %b want %b", i, outs(), exp_v);
      end
    end
  endtask

  task automatic test_stop();
    int ticks = 0;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0);
      if (i >= 3) ticks += int'(bus.tick);
      checks++;
      if (outs() !== exp_v) begin
        failures++;
        $display("FAIL stop cyc%0d: got %b want %b", i, outs(), exp_v);
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.clk_out !== 1'b0 || ticks !== 0) begin
      failures++;
      $display("FAIL stop_idle: got busy=%b clk_out=%b ticks=%0d want 0 0 0",
               bus.busy, bus.clk_out, ticks);
    end
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 7);
    cycle(1, 1, 0, 0);
    checks++;
    if (outs() !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid: got %b want %b", outs(), 5'b0);
    end
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, 0, 0);
      acks += int'(bus.div_ack);
      checks++;
      if (outs() !== exp_v) begin
        failures++;
        $display("FAIL reset_mid_restart cyc%0d: got %b want %b", i, outs(), exp_v);
      end
    end
    checks++;
    if (acks !== 0) begin
      failures++;
      $display("FAIL reset_mid_acks: got %0d want 0", acks);
    end
  endtask

  task automatic test_max_div();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 65535);
    for (int i = 0; i < 40; i++) begin
      cycle(0, 1, 0, 0);
      checks++;
      if (outs() !== exp_v) begin
        failures++;
        $display("FAIL max_div cyc%0d: got %b want %b", i, outs(), exp_v);
      end
    end
  endtask

  task automatic test_random();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(199) == 0,
            $urandom_range(99) < 80,
            $urandom_range(99) < 15,
            int'($urandom_range(9)));
      checks++;
      if (outs() !== exp_v) begin
        failures++;
        $display("FAIL random cyc%0d: got %b want %b", i, outs(), exp_v);
      end
    end
  endtask

  initial begin
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = '0;
    test_reset();
    test_default_div();
    test_idle_load();
    test_running_load();
    test_err();
    test_stop();
    test_reset_mid();
    test_max_div();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
